// File: rtl/register_file_if.sv
// Sequencer-to-register-file bus: two independent ports with enables,
// write strobes, indices, write data and registered read data.
interface register_file_if;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned IDX_W  = 4;

    logic              rega_en;
    logic              rega_wen;
    logic              regb_en;
    logic              regb_wen;
    logic              bytex;
    logic              a0;
    logic [IDX_W-1:0]  arga_x;
    logic [IDX_W-1:0]  argb_x;
    logic [DATA_W-1:0] rega_din;
    logic [DATA_W-1:0] regb_din;
    logic [DATA_W-1:0] rega_dout;
    logic [DATA_W-1:0] regb_dout;

    modport master (
        output rega_en, rega_wen, regb_en, regb_wen, bytex, a0,
               arga_x, argb_x, rega_din, regb_din,
        input  rega_dout, regb_dout
    );

    modport slave (
        input  rega_en, rega_wen, regb_en, regb_wen, bytex, a0,
               arga_x, argb_x, rega_din, regb_din,
        output rega_dout, regb_dout
    );
endinterface

// File: rtl/register_file.sv
// Dual-port 16 x 16-bit register file: port A word/byte writes, port B word
// writes, registered reads that forward same-edge writes. Port A wins collisions.
module register_file (
    input  logic           clk,
    input  logic           reset,
    register_file_if.slave bus
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned BYTE_W = 8;
    localparam logic BYTEX_WORD = 1'b0;
    localparam logic BYTEX_BYTE = 1'b1;

    logic [DATA_W-1:0] mem      [DEPTH];
    logic [DATA_W-1:0] mem_next [DEPTH];
    logic [DATA_W-1:0] rega_dout_q;
    logic [DATA_W-1:0] regb_dout_q;
    logic              wr_a;
    logic              wr_b;

    assign wr_a = bus.rega_en & bus.rega_wen;
    assign wr_b = bus.regb_en & bus.regb_wen;

    // Post-edge register image; A is applied after B so it overrides the lanes it writes.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_next[i] = mem[i];
        end
        if (wr_b) begin
            mem_next[bus.argb_x] = bus.regb_din;
        end
        if (wr_a) begin
            case (bus.bytex)
                BYTEX_WORD: mem_next[bus.arga_x] = bus.rega_din;
                BYTEX_BYTE: begin
                    if (bus.a0) begin
                        mem_next[bus.arga_x][DATA_W-1:BYTE_W] = bus.rega_din[BYTE_W-1:0];
                    end else begin
                        mem_next[bus.arga_x][BYTE_W-1:0] = bus.rega_din[BYTE_W-1:0];
                    end
                end
            endcase
        end
    end

    // Reads return the post-edge image, so same-edge writes are forwarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rega_dout_q <= '0;
            regb_dout_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= mem_next[i];
            end
            if (bus.rega_en) begin
                rega_dout_q <= mem_next[bus.arga_x];
            end
            if (bus.regb_en) begin
                regb_dout_q <= mem_next[bus.argb_x];
            end
        end
    end

    assign bus.rega_dout = rega_dout_q;
    assign bus.regb_dout = regb_dout_q;
endmodule

// File: doc/register_file.md
# register_file

Dual-port 16 x 16-bit general register file. It is the responder to the register sequencer's REGA_EN/REGA_WEN/REGB_EN/REGB_WEN strobes and executes the reads and write-backs that the sequencer requests in each FETCH/DECODE/EXECUTE/COMMIT instruction cycle. Port A supports word or byte-lane writes selected by BYTEX/A0. Port B is word-only and carries pointer updates.

## Interface
- Parameters: none. Fixed at 16 registers x 16 bits; BYTEX encodings come from constants.v (`BYTEX_WORD`, `BYTEX_BYTE`).
- Clocking and reset: one clock; reset is synchronous and active-high.
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high; clears all state.
- REGA_EN  in  1  port A enable, from the sequencer.
- REGA_WEN  in  1  port A write enable; effective only with REGA_EN=1.
- REGB_EN  in  1  port B enable.
- REGB_WEN  in  1  port B write enable; effective only with REGB_EN=1.
- BYTEX  in  1  port A write width, `BYTEX_WORD` or `BYTEX_BYTE`.
- A0  in  1  byte lane select for port A byte writes: 0 = low lane [7:0], 1 = high lane [15:8].
- ARGA_X  in  4  port A register index.
- ARGB_X  in  4  port B register index.
- REGA_DIN  in  16  port A write data.
- REGB_DIN  in  16  port B write data.
- REGA_DOUT  out  16  port A read data, registered.
- REGB_DOUT  out  16  port B read data, registered.

## Operation
- Storage: R0..R15, 16 bits each. No register is hardwired.
- Port A write condition: REGA_EN & REGA_WEN at a rising edge.
  - `BYTEX_WORD`: R[ARGA_X] <= REGA_DIN.
  - `BYTEX_BYTE`, A0=0: R[ARGA_X][7:0] <= REGA_DIN[7:0]; [15:8] unchanged.
  - `BYTEX_BYTE`, A0=1: R[ARGA_X][15:8] <= REGA_DIN[7:0]; [7:0] unchanged.
  - The byte source is always REGA_DIN[7:0]. REGA_DIN[15:8] is ignored in byte mode.
- Port B write condition: REGB_EN & REGB_WEN. Always a full word: R[ARGB_X] <= REGB_DIN. BYTEX and A0 are ignored on port B.
- Collision (both ports write the same index on the same edge): port A wins on the lanes it writes.
  - A word write: the result is REGA_DIN.
  - A byte write: the A-selected lane takes REGA_DIN[7:0]; the other lane takes the matching lane of REGB_DIN.
- Reads: at each edge with REGx_EN=1, REGx_DOUT <= the post-edge value of R[ARGx_X]. Any write on the same edge, from either port including a collision result, is forwarded. REGx_WEN does not gate the read.
- Hold: with REGx_EN=0, REGx_DOUT holds its last value and no write occurs on that port.
- A port with WEN=1 and EN=0 does nothing.

## Timing
- Reset: on an edge with RESET=1, R0..R15 <= 0 and REGA_DOUT = REGB_DOUT = 0.
  - Reset overrides any concurrent write or read, including a write issued mid-instruction.
  - The first edge with RESET=0 operates normally.
- Write latency: the register updates at the edge where the enables are sampled high. A read of that index on a later edge returns the new value.
- Read latency: one cycle. DOUT is valid after the edge on which EN is sampled.
  - Sequencer DECODE enable gives DOUT valid through EXECUTE.
  - COMMIT write-back gives DOUT showing the written value from the following cycle.
- Back-to-back writes to the same register on consecutive edges apply in order. There are no stalls and no handshakes; every request completes in its own cycle.
- Index changes take effect at the next sampled edge. There is no wrap or overflow behaviour; indices are a full 4-bit decode.

## Test plan
- Reset clear:
  - Stimulus: write R3=16'hBEEF, then assert RESET for 1 cycle.
  - Required response: R3 reads 0; both DOUT are 0 immediately after the reset edge.
- Word write/read on both ports:
  - Stimulus: A writes R1=16'h1234 and B writes R2=16'h5678 on the same edge.
  - Required response: the next read of R1 on A and R2 on B returns 16'h1234 and 16'h5678.
  - Also: with EN=0 afterwards, both DOUT hold those values.
- Byte lanes (R4 preset to 16'hAAAA):
  - A byte write A0=0, DIN=16'hFF12 gives 16'hAA12.
  - Then A0=1, DIN=16'h0034 gives 16'h3412.
  - A word write with BYTEX ignored on port B: B writes R4=16'h0001 with `BYTEX_BYTE` and reads back 16'h0001.
- Collisions at R5:
  - A word 16'h1111 with B 16'h2222 gives 16'h1111.
  - A byte A0=0, DIN=16'h0033, with B 16'h4444 gives 16'h4433.
- Forwarding:
  - Stimulus: R6=16'h0000, then one edge with REGA_EN=REGA_WEN=1, DIN=16'hCAFE, and ARGB_X=6 with REGB_EN=1 read-only.
  - Required response: both DOUT show 16'hCAFE after that edge.
- Reset mid-operation: a write of R7=16'h9999 on the same edge as RESET=1 leaves R7=0.
